ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/tron_pkg.sv | 27 ++
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared PS/2 host-transmit definitions: FSM encoding, frame edge counts,
// keyboard command bytes and the frame parity helper.
package tron_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    START    = 3'd2,
    SHIFT    = 3'd3,
    ACK      = 3'd4,
    WAIT_REL = 3'd5
  } ps2_tx_state_e;

  localparam logic [3:0] DATA_BITS   = 4'd8;
  localparam logic [3:0] PARITY_EDGE = 4'd9;
  localparam logic [3:0] STOP_EDGE   = 4'd10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one asynchronous PS/2 line with a falling-edge
// strobe taken from the synchronized value.
module ps2_sync_edge (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic line_raw,
  output logic line_sync,
  output logic line_fall
);

  logic [1:0] sync_r;
  logic       prev_r;

  // Synchronizer chain plus delayed copy; resets to the idle-high bus level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], line_raw};
      prev_r <= sync_r[1];
    end
  end

  assign line_sync = sync_r[1];
  assign line_fall = prev_r & ~sync_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, parity,
// stop, device ack). Define PS2TX_TIMEOUT_EN to add the per-transfer watchdog.
module ps2_host_tx
  import tron_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       PS2_KBCLK_in,
  input  logic       PS2_KBDAT_in,
  output logic       kbclk_oe,
  output logic       kbdat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int             IW       = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0]  INH_LAST = IW'(INHIBIT_CYCLES - 1);

  ps2_tx_state_e state_r, state_s;
  logic [IW-1:0] inh_r, inh_s;
  logic [3:0]    n_r, n_s;
  logic [8:0]    tx_r, tx_s;
  logic          kbclk_oe_r, kbclk_oe_s;
  logic          kbdat_oe_r, kbdat_oe_s;
  logic          done_r, done_s;
  logic          ack_err_r, ack_err_s;
  logic          cmd_ready_r, busy_r;
  logic          kbclk_s, kbclk_fall_s, kbdat_s;
  logic [1:0]    dat_sync_r;
  logic          wd_hit_s;

  ps2_sync_edge u_clk_sync (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .line_raw  (PS2_KBCLK_in),
    .line_sync (kbclk_s),
    .line_fall (kbclk_fall_s)
  );

  // Data line only needs synchronizing; it is sampled on clock edges.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dat_sync_r <= 2'b11;
    end else begin
      dat_sync_r <= {dat_sync_r[0], PS2_KBDAT_in};
    end
  end
  assign kbdat_s = dat_sync_r[1];

`ifdef PS2TX_TIMEOUT_EN
  localparam int            WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_r;
  logic          timeout_r;

  assign wd_hit_s = (state_r != IDLE) && (wd_r == WD_LAST);

  // Watchdog restarts on accept and fires exactly TIMEOUT_CYCLES later.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else if (state_r == IDLE) begin
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else begin
      wd_r      <= wd_r + WW'(1);
      timeout_r <= wd_hit_s;
    end
  end
  assign timeout = timeout_r;
`else
  assign wd_hit_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Next-state, datapath and line-drive decode; outputs follow the next state.
  always_comb begin
    state_s   = state_r;
    inh_s     = inh_r;
    n_s       = n_r;
    tx_s      = tx_r;
    done_s    = 1'b0;
    ack_err_s = 1'b0;

    if (wd_hit_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            state_s = INHIBIT;
            inh_s   = '0;
            n_s     = 4'd0;
            tx_s    = {odd_parity(cmd_data), cmd_data};
          end else begin
            state_s = IDLE;
          end
        end
        INHIBIT: begin
          if (inh_r == INH_LAST) begin
            state_s = START;
          end else begin
            inh_s = inh_r + IW'(1);
          end
        end
        START: state_s = SHIFT;
        SHIFT: begin
          if (kbclk_fall_s) begin
            n_s = n_r + 4'd1;
            if (n_s == STOP_EDGE) begin
              state_s = ACK;
            end else begin
              tx_s = {1'b0, tx_r[8:1]};
            end
          end else begin
            n_s = n_r;
          end
        end
        ACK: begin
          if (kbclk_fall_s) begin
            if (kbdat_s) begin
              ack_err_s = 1'b1;
              state_s   = IDLE;
            end else begin
              state_s = WAIT_REL;
            end
          end else begin
            state_s = ACK;
          end
        end
        WAIT_REL: begin
          if (kbclk_s && kbdat_s) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_REL;
          end
        end
        default: state_s = IDLE;
      endcase
    end

    kbclk_oe_s = (state_s == INHIBIT) || (state_s == START);

    // Start bit is held through SHIFT until the first edge replaces it with bit 0.
    case (state_s)
      START: kbdat_oe_s = 1'b1;
      SHIFT: begin
        if ((state_r == SHIFT) && kbclk_fall_s) begin
          kbdat_oe_s = ~tx_r[0];
        end else begin
          kbdat_oe_s = kbdat_oe_r;
        end
      end
      default: kbdat_oe_s = 1'b0;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r     <= IDLE;
      inh_r       <= '0;
      n_r         <= 4'd0;
      tx_r        <= 9'd0;
      kbclk_oe_r  <= 1'b0;
      kbdat_oe_r  <= 1'b0;
      done_r      <= 1'b0;
      ack_err_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      inh_r       <= inh_s;
      n_r         <= n_s;
      tx_r        <= tx_s;
      kbclk_oe_r  <= kbclk_oe_s;
      kbdat_oe_r  <= kbdat_oe_s;
      done_r      <= done_s;
      ack_err_r   <= ack_err_s;
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign kbclk_oe  = kbclk_oe_r;
  assign kbdat_oe  = kbdat_oe_r;
  assign done      = done_r;
  assign ack_err   = ack_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device model on wired-AND lines,
// table of commands with hand-derived frames, and multi-cycle corner sequences.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TMO = 12000;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, kbclk_oe, kbdat_oe, busy, done, ack_err, timeout;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       kbclk_line, kbdat_line;

  assign kbclk_line = dev_clk & ~kbclk_oe;
  assign kbdat_line = dev_dat & ~kbdat_oe;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .PS2_KBCLK_in (kbclk_line),
    .PS2_KBDAT_in (kbdat_line),
    .kbclk_oe     (kbclk_oe),
    .kbdat_oe     (kbdat_oe),
    .busy         (busy),
    .done         (done),
    .ack_err      (ack_err),
    .timeout      (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, err_cnt = 0, tmo_cnt = 0;
  int run = 0, last_run = 0;

  // Pulse counters and kbclk_oe high-run length, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (ack_err === 1'b1) err_cnt <= err_cnt + 1;
    if (timeout === 1'b1) tmo_cnt <= tmo_cnt + 1;
    if (kbclk_oe === 1'b1) begin
      run <= run + 1;
    end else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    bit          ack;
    bit          spam;
    logic [10:0] frame;   // {stop, parity, data[7:0], start}, bit k = k-th bit on the wire
  } vec_t;

  typedef struct {
    logic [10:0] frame;
    bit          ack;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge CLOCK_50);
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    check("kbclk_oe_after_accept", {31'd0, kbclk_oe}, 32'd1);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Device model: waits for the host to release the clock, then clocks n_edges
  // bits, sampling the line while the clock is high before each falling edge.
  task automatic dev_xfer(input int n_edges, input bit do_ack,
                          output logic [10:0] frame, output bit ok);
    int w;
    frame = 11'd0;
    w = 0;
    while (kbclk_oe !== 1'b0 && w < INH + 100) begin
      @(negedge CLOCK_50);
      w++;
    end
    ok = (kbclk_oe === 1'b0);
    repeat (10) @(negedge CLOCK_50);
    for (int k = 0; k < n_edges; k++) begin
      repeat (15) @(negedge CLOCK_50);
      frame[k] = kbdat_line;
      if (k == 10 && do_ack) dev_dat = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (20) @(negedge CLOCK_50);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    logic [10:0] fr;
    bit          ok;
    exp_t        e;
    int          d0, e0, t0, c;

    vecs[0] = '{8'hED, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}};
    vecs[1] = '{8'hF4, 1'b1, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0}};
    vecs[2] = '{8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}};
    vecs[3] = '{8'h55, 1'b0, 1'b0, {1'b1, 1'b1, 8'h55, 1'b0}};
    vecs[4] = '{8'hED, 1'b1, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}};

    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_kbclk_oe", {31'd0, kbclk_oe}, 32'd0);
    check("rst_kbdat_oe", {31'd0, kbdat_oe}, 32'd0);
    check("rst_pulses", {29'd0, done, ack_err, timeout}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt; e0 = err_cnt; t0 = tmo_cnt;
      sb_q.push_back('{vecs[i].frame, vecs[i].ack});
      send(vecs[i].cmd);
      if (vecs[i].spam) begin
        cmd_valid = 1'b1;
        cmd_data  = 8'hFF;
        repeat (3) @(negedge CLOCK_50);
        cmd_valid = 1'b0;
      end
      dev_xfer(11, vecs[i].ack, fr, ok);
      check("release_wait", {31'd0, ok}, 32'd1);
      e = sb_q.pop_front();
      check("frame", {21'd0, fr}, {21'd0, e.frame});
      check("kbclk_oe_width", last_run, 32'd5001);
      repeat (50) @(negedge CLOCK_50);
      check("done_count", done_cnt - d0, e.ack ? 32'd1 : 32'd0);
      check("ack_err_count", err_cnt - e0, e.ack ? 32'd0 : 32'd1);
      check("timeout_count", tmo_cnt - t0, 32'd0);
      check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      if (vecs[i].spam) begin
        repeat (100) @(negedge CLOCK_50);
        check("spam_not_sent", {30'd0, busy, kbclk_oe}, 32'd0);
      end
    end

    // Reset after the 4th falling edge of 0xF0: bit 3 is 0, so data is pulled low.
    d0 = done_cnt; e0 = err_cnt; t0 = tmo_cnt;
    send(8'hF0);
    dev_xfer(4, 1'b0, fr, ok);
    check("rst_mid_release_wait", {31'd0, ok}, 32'd1);
    @(negedge CLOCK_50);
    check("pre_rst_kbdat_oe", {31'd0, kbdat_oe}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("mid_rst_lines", {30'd0, kbclk_oe, kbdat_oe}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (100) @(negedge CLOCK_50);
    check("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0) + (tmo_cnt - t0), 32'd0);

    // Device never clocks.
    d0 = done_cnt; t0 = tmo_cnt;
    send(8'h11);
`ifdef PS2TX_TIMEOUT_EN
    c = 0;
    while (timeout !== 1'b1 && c < TMO + 100) begin
      @(negedge CLOCK_50);
      c++;
    end
    check("timeout_latency", c, TMO);
    @(negedge CLOCK_50);
    check("timeout_lines", {30'd0, kbclk_oe, kbdat_oe}, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_count", tmo_cnt - t0, 32'd1);
    check("timeout_no_done", done_cnt - d0, 32'd0);
`else
    repeat (TMO + 100) @(negedge CLOCK_50);
    check("no_wd_busy", {31'd0, busy}, 32'd1);
    check("no_wd_timeout", tmo_cnt - t0, 32'd0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("no_wd_recover", {31'd0, cmd_ready}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
